traffic_sensor_conditioner: RTL and testbench
=============================================

# traffic_sensor_conditioner

Conditions the two raw vehicle-loop detector inputs into the clean traffic-present flags `T1` (street A) and `T2` (street B) consumed by `fsm_traffic_controller`. It sits directly upstream of that controller. Each channel has three stages:
- synchronization of the raw input;
- debounce of both edges;
- a hold-extension, so a short gap between vehicles does not toggle the controller.

An optional stuck-sensor detector stops a jammed loop from starving the other street.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive synchronized samples needed to accept a level change (legal range ≥1).
- `HOLD`, default 8: cycles `Tn` stays high after an accepted vehicle departure (legal range ≥0).
- `STUCK`, default 1024: consecutive synchronized-high cycles that declare a sensor fault (legal range > `DEBOUNCE`).
- Counter widths are derived internally with `$clog2` of each limit plus 1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `raw_a` in 1: street-A loop detector. Asynchronous, may glitch.
- `raw_b` in 1: street-B loop detector. Asynchronous, may glitch.
- `T1` out 1: registered; 1 means traffic present on street A.
- `T2` out 1: registered; 1 means traffic present on street B.
- `fault_a` out 1: registered, sticky; street-A sensor declared stuck.
- `fault_b` out 1: registered, sticky; street-B sensor declared stuck.

## Operation
- The two channels are identical and independent. The description below uses A (`raw_a`, `T1`, `fault_a`); B is the same with `raw_b`, `T2`, `fault_b`.
- **Synchronizer:** a 2-flop synchronizer produces `s_a`. Only `s_a` is used downstream.
- **Per-channel FSM and its debounce counter `cnt`:**
  - IDLE (`T1`=0): `s_a`=1 → QUAL with `cnt`=1.
  - QUAL (`T1`=0): `s_a`=1 increments `cnt`. When `cnt` reaches `DEBOUNCE` → PRESENT. `s_a`=0 → IDLE with `cnt`=0.
  - PRESENT (`T1`=1): `s_a`=0 increments `cnt`, and `cnt` reaching `DEBOUNCE` → HOLD. `s_a`=1 clears `cnt`.
  - HOLD (`T1`=1): the hold counter counts up. On reaching `HOLD` → IDLE, with `T1` falling on the same edge. Any `s_a`=1 sample → PRESENT immediately; `T1` never drops.
  - `HOLD`=0: the FSM passes through HOLD for zero cycles, i.e. PRESENT goes directly to IDLE.
- **`T1` output:** registered, equal to 1 in PRESENT and HOLD, except where forced by a fault (see Configuration).
- **Stuck counter:** saturating. It increments on every `s_a`=1 cycle and clears on `s_a`=0. When it reaches `STUCK`, `fault_a` is set and the counter saturates.
- **Reset:** `reset`=1 at any edge, including mid-debounce or mid-hold, clears on that edge:
  - synchronizer flops;
  - FSM state (to IDLE);
  - all counters;
  - `T1`, `T2`, `fault_a` and `fault_b`.

## Timing
- **Reset values:** `T1`=`T2`=`fault_a`=`fault_b`=0.
- **Assertion latency:** `raw_a` rises and is held. Taking the first edge that samples it high as edge 0, `T1` goes to 1 after edge `DEBOUNCE`+1 (default: edge 5).
- **Deassertion latency:** `raw_a` falls and stays low. Taking the first edge that samples it low as edge 0, `T1` goes to 0 after edge `DEBOUNCE`+`HOLD`+1 (default: edge 13).
- **Glitch rejection:** a high pulse shorter than `DEBOUNCE` synchronized cycles never asserts `T1`. A low gap shorter than `DEBOUNCE`+`HOLD` cycles never deasserts it.
- **Fault latency:** `fault_a` rises after the `STUCK`-th consecutive high sample of `s_a`.
- **Channel independence:** simultaneous events on A and B are handled independently in the same cycle; there is no arbitration.

## Configuration
- Macro `TRAFFIC_SENSOR_FAULT_EN`.
- **Defined:**
  - stuck counters are built;
  - while `fault_a`=1, `T1` is forced to 0 so the controller keeps cycling;
  - `fault_a` remains 1 until `reset`, even if `raw_a` later returns low.
- **Undefined:**
  - no stuck counters;
  - `fault_a`=`fault_b`=0 constantly;
  - `T1`/`T2` are driven purely by the FSMs;
  - the `STUCK` parameter is ignored.

## Test plan
Bench parameters: `DEBOUNCE`=4, `HOLD`=8, `STUCK`=64, 10 ns clock. Vehicle and glitch scenarios are exercised on channel A, and repeated on channel B with `raw_b` → `T2` / `fault_b` (scenario 4 covers both channels at once).
1. Reset for 2 cycles with `raw_a`=`raw_b`=1 → `T1`=`T2`=`fault_a`=`fault_b`=0 throughout the reset. Release reset → `T1` rises at edge 5 after release.
2. `raw_a` high for 3 cycles, then low → `T1` stays 0. Then high for 10 cycles → `T1`=1 after edge 5.
3. While `T1`=1: `raw_a` low for 6 cycles, then high → `T1` never drops. Then low for good → `T1`=0 exactly after edge 13.
4. `raw_a` and `raw_b` rise on the same edge → `T1` and `T2` rise on the same edge 5. Drop only `raw_b` → `T2` falls at edge 13 while `T1` stays 1.
5. Start `raw_a` low with `T1`=0, raise it, then assert `reset` at edge 3 (mid-QUAL) → `T1` stays 0. After release, the full `DEBOUNCE` count restarts, so `T1` rises at edge 5 after release.
6. With `TRAFFIC_SENSOR_FAULT_EN`: hold `raw_a` high for 70 cycles → `fault_a`=1 after the 64th sample and `T1` forced to 0. Then drop `raw_a` → `fault_a` stays 1 until reset. Without the macro: `fault_a` stays 0 and `T1` stays 1.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: turns the two raw vehicle-loop inputs into the clean
// traffic-present flags T1 (street A) and T2 (street B).
// Each channel has a 2-flop synchronizer, edge debounce and a hold extension.
// Optional feature macro: TRAFFIC_SENSOR_FAULT_EN adds a sticky stuck-sensor
// detector per channel that forces the matching Tn low while the fault is set.
module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 8,
  parameter int unsigned STUCK    = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic T1,
  output logic T2,
  output logic fault_a,
  output logic fault_b
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Index 0 is street A, index 1 is street B.
  logic [1:0]        sync1_q, sync1_d;
  logic [1:0]        s_q, s_d;
  logic [1:0]        t_q, t_d;
  logic [1:0]        fault_q, fault_d;
  logic [1:0]        fsm_t;
  state_e            state_q [2];
  state_e            state_d [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic [CNT_W-1:0]  cnt_inc [2];
  logic [HOLD_W-1:0] hold_q  [2];
  logic [HOLD_W-1:0] hold_d  [2];
  logic [HOLD_W-1:0] hold_inc[2];

`ifdef TRAFFIC_SENSOR_FAULT_EN
  localparam int unsigned STUCK_W = $clog2(STUCK) + 1;
  logic [STUCK_W-1:0] stuck_q[2];
  logic [STUCK_W-1:0] stuck_d[2];
`endif

  // Two-stage synchronizer for the asynchronous loop inputs.
  always_comb begin
    sync1_d = {raw_b, raw_a};
    s_d     = sync1_q;
  end

  // Per-channel debounce / hold FSM next-state.
  always_comb begin
    fsm_t = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      hold_d[i]   = hold_q[i];
      cnt_inc[i]  = cnt_q[i] + CNT_W'(1);
      hold_inc[i] = hold_q[i] + HOLD_W'(1);
      case (state_q[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (s_q[i]) begin
            if (DEBOUNCE <= 1) begin
              state_d[i] = ST_PRESENT;
            end else begin
              state_d[i] = ST_QUAL;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        ST_QUAL: begin
          if (!s_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_inc[i] >= CNT_W'(DEBOUNCE)) begin
            state_d[i] = ST_PRESENT;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        ST_PRESENT: begin
          if (s_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_inc[i] >= CNT_W'(DEBOUNCE)) begin
            // A zero-length hold skips straight back to IDLE.
            state_d[i] = (HOLD == 0) ? ST_IDLE : ST_HOLD;
            cnt_d[i]   = '0;
            hold_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        ST_HOLD: begin
          if (s_q[i]) begin
            state_d[i] = ST_PRESENT;
            cnt_d[i]   = '0;
            hold_d[i]  = '0;
          end else if (hold_inc[i] >= HOLD_W'(HOLD)) begin
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
          end else begin
            hold_d[i] = hold_inc[i];
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
          hold_d[i]  = '0;
        end
      endcase
      fsm_t[i] = (state_d[i] == ST_PRESENT) || (state_d[i] == ST_HOLD);
    end
  end

  // Stuck-sensor detection and final traffic flag.
`ifdef TRAFFIC_SENSOR_FAULT_EN
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stuck_d[i] = '0;
      if (s_q[i]) begin
        stuck_d[i] = (stuck_q[i] == STUCK_W'(STUCK)) ? stuck_q[i]
                                                     : stuck_q[i] + STUCK_W'(1);
      end
      fault_d[i] = fault_q[i] | (stuck_d[i] == STUCK_W'(STUCK));
    end
    t_d = fsm_t & ~fault_d;
  end
`else
  always_comb begin
    // STUCK is always > DEBOUNCE >= 1, so the fault flags stay constant zero.
    fault_d = {2{STUCK == 32'd0}};
    t_d     = fsm_t;
  end
`endif

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
      t_q     <= '0;
      fault_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
`ifdef TRAFFIC_SENSOR_FAULT_EN
        stuck_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      t_q     <= t_d;
      fault_q <= fault_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
`ifdef TRAFFIC_SENSOR_FAULT_EN
        stuck_q[i] <= stuck_d[i];
`endif
      end
    end
  end

  assign T1      = t_q[0];
  assign T2      = t_q[1];
  assign fault_a = fault_q[0];
  assign fault_b = fault_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed scenarios plus random loop
// activity, checked every cycle against a run-length reference model.
module tb_traffic_sensor_conditioner;

  localparam int D = 4;
  localparam int H = 8;
  localparam int S = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic T1, T2, fault_a, fault_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: synchronizer pipe plus consecutive-run lengths of s.
  logic m_sync1[2];
  logic m_s[2];
  logic m_t[2];
  logic m_f[2];
  int   m_ones[2];
  int   m_zeros[2];

  traffic_sensor_conditioner #(.DEBOUNCE(D), .HOLD(H), .STUCK(S)) dut (
    .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b),
    .T1(T1), .T2(T2), .fault_a(fault_a), .fault_b(fault_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  // Advance the model by one rising edge with the inputs that edge samples.
  task automatic model_edge(input logic ra, input logic rb, input logic rst);
    logic raw;
    for (int i = 0; i < 2; i++) begin
      raw = (i == 0) ? ra : rb;
      if (rst) begin
        m_sync1[i] = 1'b0; m_s[i] = 1'b0; m_t[i] = 1'b0; m_f[i] = 1'b0;
        m_ones[i]  = 0;    m_zeros[i] = 0;
      end else begin
        if (m_s[i]) begin m_ones[i]++; m_zeros[i] = 0; end
        else        begin m_zeros[i]++; m_ones[i] = 0; end
        if (!m_t[i] && m_ones[i] >= D)          m_t[i] = 1'b1;
        else if (m_t[i] && m_zeros[i] >= D + H) m_t[i] = 1'b0;
`ifdef TRAFFIC_SENSOR_FAULT_EN
        if (m_ones[i] >= S) m_f[i] = 1'b1;
`endif
        m_s[i]     = m_sync1[i];
        m_sync1[i] = raw;
      end
    end
  endtask

  // One clock: apply inputs, take the edge, compare all outputs 1 ns later.
  task automatic step(input logic ra, input logic rb, input logic rst);
    raw_a = ra; raw_b = rb; reset = rst;
    @(posedge clk);
    model_edge(ra, rb, rst);
    #1;
    check("T1",      T1,      m_t[0] & ~m_f[0]);
    check("T2",      T2,      m_t[1] & ~m_f[1]);
    check("fault_a", fault_a, m_f[0]);
    check("fault_b", fault_b, m_f[1]);
  endtask

  task automatic drive(input int ch, input logic v, input logic rst);
    if (ch == 0) step(v, 1'b0, rst);
    else         step(1'b0, v, rst);
  endtask

  function automatic logic t_of(input int ch);
    return (ch == 0) ? T1 : T2;
  endfunction

  // Short pulse is rejected, then a held level asserts after D+1 edges.
  task automatic scen_pulse_rise(input int ch);
    logic seen;
    int   first;
    drive(ch, 1'b0, 1'b1);
    drive(ch, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++)  begin drive(ch, 1'b1, 1'b0); seen |= t_of(ch); end
    for (int k = 0; k < 20; k++) begin drive(ch, 1'b0, 1'b0); seen |= t_of(ch); end
    check($sformatf("ch%0d_short_pulse", ch), seen, 1'b0);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      drive(ch, 1'b1, 1'b0);
      if (first < 0 && t_of(ch)) first = k;
    end
    check($sformatf("ch%0d_rise_edge", ch), first, D + 1);
  endtask

  // Short gap keeps Tn high; a lasting drop releases it after D+H+1 edges.
  task automatic scen_gap_fall(input int ch);
    logic dropped;
    int   first;
    dropped = 1'b0;
    for (int k = 0; k < 6; k++) begin drive(ch, 1'b0, 1'b0); dropped |= ~t_of(ch); end
    for (int k = 0; k < 8; k++) begin drive(ch, 1'b1, 1'b0); dropped |= ~t_of(ch); end
    check($sformatf("ch%0d_gap_hold", ch), dropped, 1'b0);
    first = -1;
    for (int k = 0; k < 30; k++) begin
      drive(ch, 1'b0, 1'b0);
      if (first < 0 && !t_of(ch)) first = k;
    end
    check($sformatf("ch%0d_fall_edge", ch), first, D + H + 1);
  endtask

  initial begin
    int  first, first2;
    logic seen;
    int  dur_a, dur_b;
    logic lvl_a, lvl_b, rst_r;

    // 1: reset with both loops high, then release.
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b1);
      seen |= T1 | T2 | fault_a | fault_b;
    end
    check("reset_outputs_low", seen, 1'b0);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (first < 0 && T1) first = k;
    end
    check("post_reset_rise", first, D + 1);

    // 2 and 3 on each channel.
    for (int ch = 0; ch < 2; ch++) begin
      scen_pulse_rise(ch);
      scen_gap_fall(ch);
    end

    // 4: simultaneous rise, then only B drops.
    step(1'b0, 1'b0, 1'b1);
    first = -1; first2 = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (first < 0 && T1)  first  = k;
      if (first2 < 0 && T2) first2 = k;
    end
    check("dual_rise_a", first, D + 1);
    check("dual_rise_b", first2, D + 1);
    first = -1; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (first < 0 && !T2) first = k;
      seen |= ~T1;
    end
    check("b_fall_edge", first, D + H + 1);
    check("a_stays_high", seen, 1'b0);

    // 5: reset in the middle of qualification restarts the count.
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin step(1'b1, 1'b0, 1'b0); seen |= T1; end
    step(1'b1, 1'b0, 1'b1);
    seen |= T1;
    check("midqual_reset_low", seen, 1'b0);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (first < 0 && T1) first = k;
    end
    check("midqual_restart_rise", first, D + 1);

    // 6: stuck sensor on A.
    step(1'b0, 1'b0, 1'b1);
    first = -1;
    for (int k = 0; k < 70; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (first < 0 && fault_a) first = k;
    end
`ifdef TRAFFIC_SENSOR_FAULT_EN
    check("fault_edge", first, S + 1);
    check("stuck_t1_forced", T1, 1'b0);
`else
    check("fault_edge", first, -1);
    check("stuck_t1_high", T1, 1'b1);
`endif
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0);
`ifdef TRAFFIC_SENSOR_FAULT_EN
    check("fault_sticky", fault_a, 1'b1);
`else
    check("fault_never", fault_a, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b1);
    check("fault_cleared", fault_a, 1'b0);

    // Random bursts on both loops with occasional resets.
    lvl_a = 1'b0; lvl_b = 1'b0; dur_a = 0; dur_b = 0;
    for (int k = 0; k < 4000; k++) begin
      if (dur_a == 0) begin
        lvl_a = ~lvl_a;
        dur_a = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 18);
      end
      if (dur_b == 0) begin
        lvl_b = ~lvl_b;
        dur_b = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 18);
      end
      rst_r = ($urandom_range(0, 399) == 0);
      step(lvl_a, lvl_b, rst_r);
      dur_a--; dur_b--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
